// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I load/store size codes and dmem responder state encoding
package riscv_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational load extract/extend and store byte-merge
//  i_word   current array word      i_lane   byte lane (addr[1:0])
//  i_funct3 RV32I size/sign code    i_wdata  right-aligned store data
//  o_rdata  extended load result    o_wword  word after merging the store
module dmem_lane_align
   import riscv_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic [31:0] o_wword
);
   // funct3[1:0] selects the size; every code other than B/H acts as a word
   logic        w_b, w_h, w_sext;
   logic [4:0]  w_shift;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_mask, w_wd;
   assign w_b     = (i_funct3[1:0] == F3_B[1:0]);
   assign w_h     = (i_funct3[1:0] == F3_H[1:0]);
   assign w_sext  = ~i_funct3[2];
   assign w_shift = {i_lane, 3'b000};
   assign w_byte  = 8'(i_word >> w_shift);
   assign w_half  = i_lane[1] ? i_word[31:16] : i_word[15:0];
   assign o_rdata = w_b ? {{24{w_sext & w_byte[7]}}, w_byte}
                  : w_h ? {{16{w_sext & w_half[15]}}, w_half} : i_word;
   // replicate store data across the word, then keep only the addressed lanes
   assign w_mask  = w_b ? (32'h0000_00FF << w_shift)
                  : w_h ? (i_lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFFFF_FFFF;
   assign w_wd    = w_b ? {4{i_wdata[7:0]}} : w_h ? {2{i_wdata[15:0]}} : i_wdata;
   assign o_wword = (i_word & ~w_mask) | (w_wd & w_mask);
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data-memory responder for the core load/store port
//  i_clk, i_reset_n (async, active-low)
//  request : i_req_valid/o_req_ready, i_req_write, i_req_addr, i_req_funct3, i_req_wdata
//  response: o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_err
//  o_busy  : high while a transaction is waiting or responding
//  Optional macro DMEM_RESPONDER_ERR_EN enables fault reporting on o_rsp_err
//  (misaligned, out-of-range, reserved funct3); otherwise o_rsp_err is 0.
module dmem_responder
   import riscv_pkg::*;
#(
   parameter int MEMORY_SIZE = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [31:0] i_req_addr,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_busy
);
   localparam int AW = $clog2(MEMORY_SIZE);
   dmem_state_t r_state;
   logic [3:0]  r_cnt;
   logic        r_write, r_err;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic [2:0]  r_funct3;
   logic [31:0] r_mem [MEMORY_SIZE];
   logic        w_idle, w_access, w_write, w_err;
   logic [31:0] w_addr, w_wdata, w_word, w_rdata, w_wword;
   logic [2:0]  w_funct3;
   logic [AW-1:0] w_idx;
   assign w_idle      = (r_state == ST_IDLE);
   assign o_req_ready = w_idle;
   assign o_rsp_valid = (r_state == ST_RESP);
   assign o_busy      = ~w_idle;
   assign o_rsp_rdata = r_rdata;
   assign o_rsp_err   = r_err;
   // with no wait states the access happens on the accept edge, from the live inputs
   assign w_write  = w_idle ? i_req_write  : r_write;
   assign w_addr   = w_idle ? i_req_addr   : r_addr;
   assign w_funct3 = w_idle ? i_req_funct3 : r_funct3;
   assign w_wdata  = w_idle ? i_req_wdata  : r_wdata;
   assign w_access = (WAIT_STATES == 0) ? (w_idle & i_req_valid)
                                        : (r_state == ST_WAIT && r_cnt == 4'd1);
   assign w_idx    = w_addr[AW+1:2];
   assign w_word   = r_mem[w_idx];
`ifdef DMEM_RESPONDER_ERR_EN
   logic w_rsvd, w_misal, w_oor;
   assign w_rsvd  = (w_funct3[1:0] == 2'b11) | (w_funct3[2:1] == 2'b11);
   // funct3[1] marks word (and reserved) codes, which are already faults
   assign w_misal = ((w_funct3[1:0] == F3_H[1:0]) & w_addr[0]) | (w_funct3[1] & |w_addr[1:0]);
   assign w_oor   = |w_addr[31:AW+2];
   assign w_err   = w_rsvd | w_misal | w_oor;
`else
   logic w_unused_ok;
   assign w_err       = 1'b0;
   assign w_unused_ok = ^w_addr[31:AW+2];
`endif
   dmem_lane_align u_align (
      .i_word   (w_word),
      .i_lane   (w_addr[1:0]),
      .i_funct3 (w_funct3),
      .i_wdata  (w_wdata),
      .o_rdata  (w_rdata),
      .o_wword  (w_wword)
   );
   // reset gating keeps a store from landing on an edge where reset is held
   always_ff @(posedge i_clk) begin
      if (i_reset_n && w_access && w_write && !w_err) r_mem[w_idx] <= w_wword;
   end
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_funct3 <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_access) begin
            r_rdata <= (w_write | w_err) ? '0 : w_rdata;
            r_err   <= w_err;
         end
         case (r_state)
            ST_IDLE: if (i_req_valid) begin
               r_write  <= i_req_write;
               r_addr   <= i_req_addr;
               r_funct3 <= i_req_funct3;
               r_wdata  <= i_req_wdata;
               r_cnt    <= 4'(WAIT_STATES);
               r_state  <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) r_state <= ST_RESP;
            end
            ST_RESP: if (i_rsp_ready) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (WAIT_STATES=1)
module tb_dmem_responder;
   import riscv_pkg::*;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata, held;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   dmem_responder #(.MEMORY_SIZE(256), .WAIT_STATES(1)) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_funct3(req_funct3), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
      .o_rsp_err(rsp_err), .o_busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "/req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "/rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "/busy"},      {31'd0, busy},      32'd0);
   endtask

   task automatic start(input logic w, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_funct3 = f3; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
   endtask

   task automatic txn(input logic w, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
      int n;
      chk({tag, "/ready_before"}, {31'd0, req_ready}, 32'd1);
      start(w, a, f3, wd);
      chk({tag, "/busy_wait"}, {31'd0, busy}, 32'd1);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      // valid one edge after the accept edge means two cycles after the handshake cycle
      chk({tag, "/latency"}, n, 32'd1);
      chk({tag, "/rdata"}, rsp_rdata, exp_rd);
      chk({tag, "/err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_idle({tag, "/release"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_idle("reset");
      chk("reset/rdata", rsp_rdata, 32'd0);
      chk("reset/err", {31'd0, rsp_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      // basic word store/load
      txn(1'b1, 32'h10, F3_W, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw10");
      txn(1'b0, 32'h10, F3_W, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw10_a");
      // byte store and byte loads
      txn(1'b1, 32'h11, F3_B, 32'hFFFF_FF55, 32'h0, 1'b0, "sb11");
      txn(1'b0, 32'h10, F3_W, 32'h0, 32'hDEAD_55EF, 1'b0, "lw10_b");
      txn(1'b0, 32'h13, F3_B, 32'h0, 32'hFFFF_FFDE, 1'b0, "lb13");
      txn(1'b0, 32'h13, F3_BU, 32'h0, 32'h0000_00DE, 1'b0, "lbu13");
      txn(1'b0, 32'h11, F3_B, 32'h0, 32'h0000_0055, 1'b0, "lb11");
      // half store and half loads
      txn(1'b1, 32'h12, F3_H, 32'hABCD_8001, 32'h0, 1'b0, "sh12");
      txn(1'b0, 32'h12, F3_H, 32'h0, 32'hFFFF_8001, 1'b0, "lh12");
      txn(1'b0, 32'h12, F3_HU, 32'h0, 32'h0000_8001, 1'b0, "lhu12");
      txn(1'b0, 32'h10, F3_H, 32'h0, 32'h0000_55EF, 1'b0, "lh10");
      txn(1'b0, 32'h10, F3_W, 32'h0, 32'h8001_55EF, 1'b0, "lw10_c");

      // backpressure: response held while a competing store is presented
      start(1'b0, 32'h10, F3_W, 32'h0);
      @(negedge clk);
      chk("bp/valid0", {31'd0, rsp_valid}, 32'd1);
      held = rsp_rdata;
      chk("bp/rdata0", held, 32'h8001_55EF);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_funct3 = F3_W; req_wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp/valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp/rdata", rsp_rdata, held);
         chk("bp/req_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_idle("bp/release");
      req_valid = 1'b0; req_write = 1'b0;
      @(negedge clk);
      check_idle("bp/after");
      txn(1'b0, 32'h10, F3_W, 32'h0, 32'h8001_55EF, 1'b0, "bp/lw10");

      // reset in WAIT drops the store
      txn(1'b1, 32'h20, F3_W, 32'hCAFE_F00D, 32'h0, 1'b0, "sw20");
      txn(1'b0, 32'h20, F3_W, 32'h0, 32'hCAFE_F00D, 1'b0, "lw20_a");
      start(1'b1, 32'h20, F3_W, 32'h0000_1234);
      chk("rst/in_wait", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle("rst/async");
      chk("rst/rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txn(1'b0, 32'h20, F3_W, 32'h0, 32'hCAFE_F00D, 1'b0, "lw20_b");

      // fault handling / forced alignment and wrap
      txn(1'b1, 32'h0, F3_W, 32'h0BAD_F00D, 32'h0, 1'b0, "sw0");
`ifdef DMEM_RESPONDER_ERR_EN
      txn(1'b0, 32'h22, F3_W, 32'h0, 32'h0, 1'b1, "err/lw22");
      txn(1'b0, 32'h13, F3_H, 32'h0, 32'h0, 1'b1, "err/lh13");
      txn(1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1, "err/f3_011");
      txn(1'b1, 32'h400, F3_W, 32'h0000_0099, 32'h0, 1'b1, "err/sw400");
      txn(1'b0, 32'h0, F3_W, 32'h0, 32'h0BAD_F00D, 1'b0, "err/lw0");
`else
      txn(1'b0, 32'h22, F3_W, 32'h0, 32'hCAFE_F00D, 1'b0, "noerr/lw22");
      txn(1'b0, 32'h13, F3_H, 32'h0, 32'hFFFF_8001, 1'b0, "noerr/lh13");
      txn(1'b0, 32'h10, 3'b011, 32'h0, 32'h8001_55EF, 1'b0, "noerr/f3_011");
      txn(1'b1, 32'h404, F3_W, 32'h1111_2222, 32'h0, 1'b0, "noerr/sw404");
      txn(1'b0, 32'h4, F3_W, 32'h0, 32'h1111_2222, 1'b0, "noerr/lw4");
      txn(1'b0, 32'h400, F3_W, 32'h0, 32'h0BAD_F00D, 1'b0, "noerr/lw400");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
